// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port ids and the
// memory request bundle used by both the request mux and the memory side.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W  = 32;
    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_BMASK_W = DMEM_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    // Field widths follow the package constants; the arbiter's width
    // parameters must stay equal to them.
    typedef struct packed {
        logic                    we;
        logic [DMEM_ADDR_W-1:0]  addr;
        logic [DMEM_DATA_W-1:0]  wdata;
        logic [DMEM_BMASK_W-1:0] bmask;
    } mem_req_t;

    // Ports allowed to win in a given state: the lock owner only, or both.
    function automatic logic [1:0] state_mask(input arb_state_e s);
        case (s)
            ARB_LOCK0: state_mask = 2'b01;
            ARB_LOCK1: state_mask = 2'b10;
            default:   state_mask = 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker. On a tie the port that did not win last
// time gets the grant; force_mask removes ports from consideration.
module arb_rr2 (
    input  logic [1:0] vld,
    input  logic       rr_last,
    input  logic [1:0] force_mask,
    output logic [1:0] gnt
);

    logic [1:0] elig;

    // One-hot grant among the eligible requesters.
    always_comb begin
        elig = vld & force_mask;
        gnt  = elig;
        if (elig == 2'b11) begin
            gnt = rr_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port synchronous-read data memory between the
// core LSU (port 0) and the debug/loader port (port 1). Round-robin per beat;
// when DMEM_ARB_BURST_EN is defined a requester may lock the memory for up
// to MAX_BURST consecutive beats.
//
// Handshake: a beat is accepted when vld & rdy. rdy never rises without its
// vld, at most one rdy is high per cycle, and the response (read data or
// write ack) appears on o_rspN_* exactly one cycle after acceptance with no
// back-pressure.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req0_vld,
    input  logic                i_req0_we,
    input  logic [ADDR_W-1:0]   i_req0_addr,
    input  logic [DATA_W-1:0]   i_req0_wdata,
    input  logic [DATA_W/8-1:0] i_req0_bmask,
    input  logic                i_req0_lock,
    output logic                o_req0_rdy,
    output logic                o_rsp0_vld,
    output logic [DATA_W-1:0]   o_rsp0_rdata,
    input  logic                i_req1_vld,
    input  logic                i_req1_we,
    input  logic [ADDR_W-1:0]   i_req1_addr,
    input  logic [DATA_W-1:0]   i_req1_wdata,
    input  logic [DATA_W/8-1:0] i_req1_bmask,
    input  logic                i_req1_lock,
    output logic                o_req1_rdy,
    output logic                o_rsp1_vld,
    output logic [DATA_W-1:0]   o_rsp1_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_owner,
    output logic                o_busy
);

    logic [1:0] vld;
    logic [1:0] force_mask;
    logic [1:0] gnt_raw;
    logic [1:0] gnt;
    logic       accept;
    logic       win_port;
    logic       rr_last;
    logic       owner;
    logic       rsp_pend;
    logic       rsp_port;
    logic       rsp_we;
    mem_req_t   req0;
    mem_req_t   req1;
    mem_req_t   mem_sel;

    assign vld = {i_req1_vld, i_req0_vld};

    arb_rr2 u_pick (
        .vld        (vld),
        .rr_last    (rr_last),
        .force_mask (force_mask),
        .gnt        (gnt_raw)
    );

    // Nothing is granted while reset is held.
    assign gnt      = i_rst ? 2'b00 : gnt_raw;
    assign accept   = |gnt;
    assign win_port = gnt[1];

    assign o_req0_rdy = gnt[0];
    assign o_req1_rdy = gnt[1];

    // Gather each port's fields and forward the winner; all zero when idle.
    always_comb begin
        req0    = '{we: i_req0_we, addr: i_req0_addr, wdata: i_req0_wdata, bmask: i_req0_bmask};
        req1    = '{we: i_req1_we, addr: i_req1_addr, wdata: i_req1_wdata, bmask: i_req1_bmask};
        mem_sel = '0;
        if (gnt[0]) begin
            mem_sel = req0;
        end else if (gnt[1]) begin
            mem_sel = req1;
        end
    end

    assign o_mem_en    = accept;
    assign o_mem_we    = mem_sel.we;
    assign o_mem_addr  = mem_sel.addr;
    assign o_mem_wdata = mem_sel.wdata;
    assign o_mem_bmask = mem_sel.bmask;

`ifdef DMEM_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             win_lock;

    assign win_lock   = win_port ? i_req1_lock : i_req0_lock;
    assign force_mask = state_mask(state);
    assign o_busy     = (state != ARB_IDLE);

    // Lock FSM next state and burst counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = burst_cnt;
        case (state)
            ARB_IDLE: begin
                if (accept && win_lock) begin
                    state_nxt = win_port ? ARB_LOCK1 : ARB_LOCK0;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            default: begin
                // A locked cycle without an accept means the owner dropped vld.
                if (!accept || !win_lock) begin
                    state_nxt = ARB_IDLE;
                end else begin
                    if (burst_cnt < MAX_CNT) begin
                        cnt_nxt = burst_cnt + 1'b1;
                    end
                    if (burst_cnt >= MAX_CNT - 1'b1) begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ARB_IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= cnt_nxt;
        end
    end
`else
    logic lock_unused;
    localparam int burst_unused = MAX_BURST;

    assign lock_unused = i_req0_lock ^ i_req1_lock;
    assign force_mask  = 2'b11;
    assign o_busy      = 1'b0;
`endif

    // Round-robin pointer, owner and one-deep response tracking.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_last  <= PORT_DBG;
            owner    <= PORT_CORE;
            rsp_pend <= 1'b0;
            rsp_port <= PORT_CORE;
            rsp_we   <= 1'b0;
        end else begin
            rsp_pend <= accept;
            if (accept) begin
                rr_last  <= win_port;
                owner    <= win_port;
                rsp_port <= win_port;
                rsp_we   <= mem_sel.we;
            end
        end
    end

    assign o_owner      = owner;
    assign o_rsp0_vld   = rsp_pend && (rsp_port == PORT_CORE);
    assign o_rsp1_vld   = rsp_pend && (rsp_port == PORT_DBG);
    assign o_rsp0_rdata = (o_rsp0_vld && !rsp_we) ? i_mem_rdata : '0;
    assign o_rsp1_rdata = (o_rsp1_vld && !rsp_we) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-masked synchronous-read
// memory attached. Burst expectations follow DMEM_ARB_BURST_EN.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req0_we, req0_lock, req0_rdy, rsp0_vld;
    logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
    logic [3:0]  req0_bmask;
    logic        req1_vld, req1_we, req1_lock, req1_rdy, rsp1_vld;
    logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [3:0]  req1_bmask;
    logic        mem_en, mem_we, owner, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_bmask;

    bit   [31:0] mem [0:255];
    int          vectors = 0;
    int          miscompares = 0;
    int          n0, n1;
    logic        t3_win  [12];
    logic        t3_busy [12];
    logic        t2_win  [6];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_vld   (req0_vld),
        .i_req0_we    (req0_we),
        .i_req0_addr  (req0_addr),
        .i_req0_wdata (req0_wdata),
        .i_req0_bmask (req0_bmask),
        .i_req0_lock  (req0_lock),
        .o_req0_rdy   (req0_rdy),
        .o_rsp0_vld   (rsp0_vld),
        .o_rsp0_rdata (rsp0_rdata),
        .i_req1_vld   (req1_vld),
        .i_req1_we    (req1_we),
        .i_req1_addr  (req1_addr),
        .i_req1_wdata (req1_wdata),
        .i_req1_bmask (req1_bmask),
        .i_req1_lock  (req1_lock),
        .o_req1_rdy   (req1_rdy),
        .o_rsp1_vld   (rsp1_vld),
        .o_rsp1_rdata (rsp1_rdata),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_bmask  (mem_bmask),
        .i_mem_rdata  (mem_rdata),
        .o_owner      (owner),
        .o_busy       (busy)
    );

    // Memory: byte-masked write, read data registered one cycle after en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_bmask[b]) mem[mem_addr[9:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input logic l);
        req0_vld = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_bmask = m; req0_lock = l;
    endtask

    task automatic set1(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input logic l);
        req1_vld = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_bmask = m; req1_lock = l;
    endtask

    initial begin
        t2_win = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        if (BURST) begin
            t3_win  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
            t3_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        end else begin
            t3_win  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            t3_busy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        end

        // Reset state: requests present but nothing granted.
        rst = 1'b1;
        set0(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b1);
        set1(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b1);
        #2;
        chk("rst_rdy0", {31'b0, req0_rdy}, 32'd0);
        chk("rst_rdy1", {31'b0, req1_rdy}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp0", {31'b0, rsp0_vld}, 32'd0);
        chk("rst_rsp1", {31'b0, rsp1_vld}, 32'd0);
        chk("rst_owner", {31'b0, owner}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Port 0 write then read-back of the same word.
        set0(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        #1;
        chk("t1_rdy0", {31'b0, req0_rdy}, 32'd1);
        chk("t1_rdy1", {31'b0, req1_rdy}, 32'd0);
        chk("t1_mem_en", {31'b0, mem_en}, 32'd1);
        chk("t1_mem_we", {31'b0, mem_we}, 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t1_mem_bmask", {28'b0, mem_bmask}, 32'hF);
        tick();
        chk("t1_wack_vld", {31'b0, rsp0_vld}, 32'd1);
        chk("t1_wack_rdata", rsp0_rdata, 32'h0);
        chk("t1_wack_rsp1", {31'b0, rsp1_vld}, 32'd0);
        chk("t1_owner", {31'b0, owner}, 32'd0);
        set0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        #1;
        chk("t1_rd_rdy0", {31'b0, req0_rdy}, 32'd1);
        chk("t1_rd_we", {31'b0, mem_we}, 32'd0);
        tick();
        chk("t1_rd_vld", {31'b0, rsp0_vld}, 32'd1);
        chk("t1_rd_rdata", rsp0_rdata, 32'hDEADBEEF);
        chk("t1_rd_rsp1", {31'b0, rsp1_vld}, 32'd0);
        // Idle with non-zero fields: memory side must be all zero.
        set0(1'b0, 1'b1, 32'h104, 32'h55, 4'hF, 1'b0);
        #1;
        chk("t1_idle_en", {31'b0, mem_en}, 32'd0);
        chk("t1_idle_we", {31'b0, mem_we}, 32'd0);
        chk("t1_idle_addr", mem_addr, 32'h0);
        chk("t1_idle_wdata", mem_wdata, 32'h0);
        chk("t1_idle_bmask", {28'b0, mem_bmask}, 32'h0);
        tick();
        chk("t1_idle_rsp0", {31'b0, rsp0_vld}, 32'd0);
        chk("t1_idle_rsp1", {31'b0, rsp1_vld}, 32'd0);

        // Both ports read every cycle from reset: strict alternation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n0 = 0;
        n1 = 0;
        set0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        set1(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t2_rdy0", {31'b0, req0_rdy}, {31'b0, ~t2_win[k]});
            chk("t2_rdy1", {31'b0, req1_rdy}, {31'b0, t2_win[k]});
            tick();
            chk("t2_rsp0", {31'b0, rsp0_vld}, {31'b0, ~t2_win[k]});
            chk("t2_rsp1", {31'b0, rsp1_vld}, {31'b0, t2_win[k]});
            if (rsp0_vld) begin
                n0++;
                chk("t2_rdata0", rsp0_rdata, 32'hDEADBEEF);
            end
            if (rsp1_vld) begin
                n1++;
                chk("t2_rdata1", rsp1_rdata, 32'h0);
            end
        end
        chk("t2_count0", n0, 32'd3);
        chk("t2_count1", n1, 32'd3);
        set0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();

        // Port 1 byte-masked partial write.
        set1(1'b1, 1'b1, 32'h300, 32'h11223344, 4'hF, 1'b0);
        #1;
        tick();
        set1(1'b1, 1'b1, 32'h300, 32'h0000AB00, 4'b0010, 1'b0);
        #1;
        chk("t6_rdy1", {31'b0, req1_rdy}, 32'd1);
        chk("t6_bmask", {28'b0, mem_bmask}, 32'h2);
        tick();
        chk("t6_wack1", {31'b0, rsp1_vld}, 32'd1);
        chk("t6_wack1_rdata", rsp1_rdata, 32'h0);
        chk("t6_owner", {31'b0, owner}, 32'd1);
        set1(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
        #1;
        tick();
        chk("t6_rd_vld", {31'b0, rsp1_vld}, 32'd1);
        chk("t6_rd_rdata", rsp1_rdata, 32'h1122AB44);
        chk("t6_rd_rsp0", {31'b0, rsp0_vld}, 32'd0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();

        // Reset in the response cycle of a read: the response is dropped.
        set0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        #1;
        chk("t5_rdy0", {31'b0, req0_rdy}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rsp0_drop", {31'b0, rsp0_vld}, 32'd0);
        chk("t5_rdata_drop", rsp0_rdata, 32'h0);
        chk("t5_rdy0_in_rst", {31'b0, req0_rdy}, 32'd0);
        set0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();
        chk("t5_rsp0_after", {31'b0, rsp0_vld}, 32'd0);
        chk("t5_rsp1_after", {31'b0, rsp1_vld}, 32'd0);
        rst = 1'b0;
        set0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        set1(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
        #1;
        chk("t5_tie_rdy0", {31'b0, req0_rdy}, 32'd1);
        chk("t5_tie_rdy1", {31'b0, req1_rdy}, 32'd0);
        tick();
        set0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();

        // Port 1 holds lock for 12 beats against a continuously valid port 0.
        set0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        set1(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("t3_rdy1", {31'b0, req1_rdy}, {31'b0, t3_win[k]});
            chk("t3_rdy0", {31'b0, req0_rdy}, {31'b0, ~t3_win[k]});
            tick();
            chk("t3_busy", {31'b0, busy}, {31'b0, t3_busy[k]});
            chk("t3_owner", {31'b0, owner}, {31'b0, t3_win[k]});
            chk("t3_rsp1", {31'b0, rsp1_vld}, {31'b0, t3_win[k]});
        end
        set0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();
        chk("t3_end_busy", {31'b0, busy}, 32'd0);

        // Locked port 0 drops vld for one cycle while port 1 waits.
        set0(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1);
        #1;
        chk("t4_rdy0", {31'b0, req0_rdy}, 32'd1);
        tick();
        chk("t4_busy_lock", {31'b0, busy}, {31'b0, BURST});
        set0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set1(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
        #1;
        chk("t4_drop_rdy1", {31'b0, req1_rdy}, {31'b0, ~BURST});
        chk("t4_drop_rdy0", {31'b0, req0_rdy}, 32'd0);
        chk("t4_drop_en", {31'b0, mem_en}, {31'b0, ~BURST});
        tick();
        chk("t4_busy_idle", {31'b0, busy}, 32'd0);
        #1;
        chk("t4_next_rdy1", {31'b0, req1_rdy}, 32'd1);
        tick();
        chk("t4_next_rsp1", {31'b0, rsp1_vld}, 32'd1);
        set1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
